servo_seq_ctrl: RTL and testbench

- Position sequencer and arbiter for the single hobby-servo PWM channel.
- Takes up to three position requesters and grants one at a time by fixed priority.
- Slews the commanded duty toward the granted target, changing it only on 20 ms frame boundaries so the PWM never glitches mid-period, then holds it for a dwell time.
- Drives `duty_out` into the PWM generator; runs on the 25 MHz iCE40 clock.

---
 rtl/servo_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_servo_seq_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_seq_ctrl.sv
// Servo position sequencer: fixed-priority requester arbiter with frame-aligned duty slewing and dwell.
// Optional build macro SERVO_AUTO_PARK_EN: when idle with no requests, slew back to DUTY_MIN.
module servo_seq_ctrl #(
    parameter int FRAME_LIMIT = 500000,
    parameter int CNT_W       = 19,
    parameter int DUTY_MIN    = 12500,
    parameter int DUTY_MAX    = 60000,
    parameter int POS0        = 23500,
    parameter int POS1        = 19000,
    parameter int POS2        = 28000,
    parameter int STEP        = 1000,
    parameter int HOLD_FRAMES = 25
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [2:0]       req,
    output logic [2:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             frame_tick,
    output logic [CNT_W-1:0] duty_out
);

    // state | meaning
    // IDLE  | waiting for a request; duty_out held (or parked, if enabled)
    // RAMP  | slewing duty toward target, one STEP per frame_tick
    // HOLD  | target reached; dwelling HOLD_FRAMES+1 frame ticks before done
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

`ifdef SERVO_AUTO_PARK_EN
    localparam bit PARK_EN = 1'b1;
`else
    localparam bit PARK_EN = 1'b0;
`endif

    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    function automatic logic [CNT_W-1:0] clamp_duty(input int pos);
        if (pos < DUTY_MIN) return CNT_W'(DUTY_MIN);
        if (pos > DUTY_MAX) return CNT_W'(DUTY_MAX);
        return CNT_W'(pos);
    endfunction

    localparam logic [CNT_W-1:0]  FRAME_C    = CNT_W'(FRAME_LIMIT);
    localparam logic [CNT_W-1:0]  DUTY_MIN_C = CNT_W'(DUTY_MIN);
    localparam logic [CNT_W-1:0]  STEP_C     = CNT_W'(STEP);
    localparam logic [CNT_W-1:0]  TGT0_C     = clamp_duty(POS0);
    localparam logic [CNT_W-1:0]  TGT1_C     = clamp_duty(POS1);
    localparam logic [CNT_W-1:0]  TGT2_C     = clamp_duty(POS2);
    localparam logic [HOLD_W-1:0] HOLD_C     = HOLD_W'(HOLD_FRAMES);

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [CNT_W-1:0]  duty_q,   duty_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [HOLD_W-1:0] hold_q,   hold_d;
    logic [2:0]        gnt_q,    gnt_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              park_q,   park_d;

    logic              tick;
    logic [2:0]        pick;
    logic [CNT_W-1:0]  pick_tgt;
    logic [CNT_W-1:0]  step_duty;

    assign tick = (cnt_q == FRAME_C);

    always_comb begin
        pick     = 3'b000;
        pick_tgt = TGT0_C;
        if (req[0]) begin
            pick     = 3'b001;
            pick_tgt = TGT0_C;
        end else if (req[1]) begin
            pick     = 3'b010;
            pick_tgt = TGT1_C;
        end else if (req[2]) begin
            pick     = 3'b100;
            pick_tgt = TGT2_C;
        end
    end

    // Compare before subtracting so the unsigned difference never wraps.
    always_comb begin
        step_duty = duty_q;
        if (target_q >= duty_q) begin
            if ((target_q - duty_q) <= STEP_C) step_duty = target_q;
            else                               step_duty = duty_q + STEP_C;
        end else begin
            if ((duty_q - target_q) <= STEP_C) step_duty = target_q;
            else                               step_duty = duty_q - STEP_C;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        duty_d   = duty_q;
        target_d = target_q;
        hold_d   = hold_q;
        gnt_d    = 3'b000;
        done_d   = 1'b0;
        park_d   = park_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d    = pick;
                    target_d = pick_tgt;
                    park_d   = 1'b0;
                    state_d  = ST_RAMP;
                end else if (PARK_EN && (duty_q != DUTY_MIN_C)) begin
                    target_d = DUTY_MIN_C;
                    park_d   = 1'b1;
                    state_d  = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (PARK_EN && park_q && (|req)) begin
                    gnt_d    = pick;
                    target_d = pick_tgt;
                    park_d   = 1'b0;
                end else if (tick) begin
                    duty_d = step_duty;
                    if (step_duty == target_q) begin
                        if (PARK_EN && park_q) begin
                            park_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            hold_d  = HOLD_C;
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    if (hold_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                park_d  = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_RAMP) || (state_d == ST_HOLD);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            duty_q   <= DUTY_MIN_C;
            target_q <= DUTY_MIN_C;
            hold_q   <= '0;
            gnt_q    <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            park_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            hold_q   <= hold_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            park_q   <= park_d;
        end
    end

    assign gnt        = gnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign frame_tick = tick;
    assign duty_out   = duty_q;

endmodule

// File: tb/tb_servo_seq_ctrl.sv
// Directed bench for servo_seq_ctrl with short frames (FRAME_LIMIT=9, STEP=4000, HOLD_FRAMES=2).
// A second instance with POS2=70000 exercises target clamping.
module tb_servo_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req,  req2;
    logic [2:0]  gnt,  gnt2;
    logic        busy, busy2;
    logic        done, done2;
    logic        frame_tick, frame_tick2;
    logic [18:0] duty_out, duty_out2;

    int errors = 0;
    int checks = 0;

    servo_seq_ctrl #(.FRAME_LIMIT(9), .STEP(4000), .HOLD_FRAMES(2)) dut (
        .clk_in(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .busy(busy),
        .done(done), .frame_tick(frame_tick), .duty_out(duty_out)
    );

    servo_seq_ctrl #(.FRAME_LIMIT(9), .STEP(4000), .HOLD_FRAMES(2), .POS2(70000)) dut_clamp (
        .clk_in(clk), .rst_n(rst_n), .req(req2), .gnt(gnt2), .busy(busy2),
        .done(done2), .frame_tick(frame_tick2), .duty_out(duty_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Advance until frame_tick is high; n returns the number of clocks taken.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step_clk();
            n++;
        end while (frame_tick !== 1'b1 && n < 20);
        chk("tick_budget", {31'd0, frame_tick}, 1);
    endtask

    task automatic hold_to_done(input string tag, input int duty_exp);
        int n;
        for (int k = 0; k < 3; k++) begin
            wait_tick(n);
            chk({tag, "_hold_busy"}, {31'd0, busy}, 1);
            chk({tag, "_hold_nodone"}, {31'd0, done}, 0);
        end
        step_clk();
        chk({tag, "_done"}, {31'd0, done}, 1);
        chk({tag, "_done_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done_duty"}, duty_out, duty_exp);
    endtask

    initial begin
        int n;
        int exp_duty;
        int bad;
        int ramp_a[3] = '{16500, 20500, 23500};
        int ramp_b[2] = '{19500, 19000};
        int ramp_c[3] = '{23000, 27000, 28000};

        rst_n = 1'b0;
        req   = 3'b000;
        req2  = 3'b000;
        repeat (3) step_clk();

        // 1. reset state and frame cadence
        chk("rst_duty", duty_out, 12500);
        chk("rst_gnt", {29'd0, gnt}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_tick", {31'd0, frame_tick}, 0);
        rst_n = 1'b1;
        wait_tick(n);
        chk("first_tick_latency", n, 9);
        wait_tick(n);
        chk("tick_period", n, 10);
        chk("idle_duty", duty_out, 12500);

        // 2. single request from requester 0
        step_clk();
        req = 3'b001;
        step_clk();
        chk("t2_gnt", {29'd0, gnt}, 3'b001);
        chk("t2_busy", {31'd0, busy}, 1);
        chk("t2_duty_at_gnt", duty_out, 12500);
        req = 3'b000;
        step_clk();
        chk("t2_gnt_pulse", {29'd0, gnt}, 0);
        for (int i = 0; i < 3; i++) begin
            wait_tick(n);
            step_clk();
            chk("t2_ramp_duty", duty_out, ramp_a[i]);
        end
        hold_to_done("t2", 23500);
        step_clk();
        chk("t2_done_pulse", {31'd0, done}, 0);

        // 3. priority between 1 and 2, then re-grant of a held request
        req = 3'b110;
        step_clk();
        chk("t3_gnt1", {29'd0, gnt}, 3'b010);
        req = 3'b100;
        for (int i = 0; i < 2; i++) begin
            wait_tick(n);
            step_clk();
            chk("t3_ramp1_duty", duty_out, ramp_b[i]);
        end
        hold_to_done("t3a", 19000);
        chk("t3_no_gnt_on_done", {29'd0, gnt}, 0);
        step_clk();
        chk("t3_gnt2_after_done", {29'd0, gnt}, 3'b100);
        chk("t3_busy2", {31'd0, busy}, 1);
        req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            wait_tick(n);
            step_clk();
            chk("t3_ramp2_duty", duty_out, ramp_c[i]);
        end
        hold_to_done("t3b", 28000);
        step_clk();

        // 4. request on a frame_tick cycle
        wait_tick(n);
        req = 3'b001;
        step_clk();
        chk("t4_gnt", {29'd0, gnt}, 3'b001);
        chk("t4_duty_no_step", duty_out, 28000);
        req = 3'b000;
        wait_tick(n);
        chk("t4_wait_full_frame", n, 9);
        chk("t4_duty_before_tick", duty_out, 28000);
        step_clk();
        chk("t4_down_step", duty_out, 24000);
        wait_tick(n);
        step_clk();
        chk("t4_down_final", duty_out, 23500);
        hold_to_done("t4", 23500);
        step_clk();

        // 6. reset mid-RAMP abandons the move without done
        rst_n = 1'b0;
        step_clk();
        rst_n = 1'b1;
        req = 3'b001;
        step_clk();
        chk("t6_gnt", {29'd0, gnt}, 3'b001);
        req = 3'b000;
        wait_tick(n);
        step_clk();
        chk("t6_ramp_a", duty_out, 16500);
        wait_tick(n);
        step_clk();
        chk("t6_ramp_b", duty_out, 20500);
        chk("t6_busy_before", {31'd0, busy}, 1);
        rst_n = 1'b0;
        step_clk();
        chk("t6_rst_duty", duty_out, 12500);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_done", {31'd0, done}, 0);
        chk("t6_rst_gnt", {29'd0, gnt}, 0);
        chk("t6_rst_tick", {31'd0, frame_tick}, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step_clk();
            if (done !== 1'b0 || busy !== 1'b0 || duty_out !== 19'd12500) bad++;
        end
        chk("t6_stays_idle", bad, 0);

        // 5. clamped target on the second instance
        req2 = 3'b100;
        step_clk();
        chk("t5_gnt", {29'd0, gnt2}, 3'b100);
        req2 = 3'b000;
        exp_duty = 12500;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            wait_tick(n);
            step_clk();
            exp_duty = (60000 - exp_duty <= 4000) ? 60000 : exp_duty + 4000;
            if (duty_out2 > 19'd60000) bad++;
            chk("t5_ramp_duty", duty_out2, exp_duty);
        end
        chk("t5_never_above_max", bad, 0);
        for (int k = 0; k < 3; k++) wait_tick(n);
        step_clk();
        chk("t5_done", {31'd0, done2}, 1);
        chk("t5_final_duty", duty_out2, 60000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
